// File: rtl/hist_pkg.sv
// Shared sizes, FSM encoding and beat record for the histogram stream reader.
package hist_pkg;
  localparam int NBINS  = 256;
  localparam int BIN_W  = 8;
  localparam int CNT_W  = 16;
  localparam int CDF_W  = 24;
  localparam int ADDR_W = 9;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [CNT_W-1:0] count;
    logic [CDF_W-1:0] cdf;
    logic             last;
  } beat_t;
endpackage

// File: rtl/histogram_stream_reader_if.sv
// Read port toward the histogram calculator plus the beat stream toward downstream.
interface histogram_stream_reader_if;
  logic                         rd_en;
  logic [hist_pkg::ADDR_W-1:0]  rd_addr;
  logic [hist_pkg::CNT_W-1:0]   rd_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [hist_pkg::BIN_W-1:0]   out_bin;
  logic [hist_pkg::CNT_W-1:0]   out_count;
  logic [hist_pkg::CDF_W-1:0]   out_cdf;
  logic                         out_last;

  modport master (output rd_en, rd_addr, out_valid, out_bin, out_count, out_cdf, out_last,
                  input  rd_data, out_ready);
  modport slave  (input  rd_en, rd_addr, out_valid, out_bin, out_count, out_cdf, out_last,
                  output rd_data, out_ready);
endinterface

// File: rtl/hist_beat_fifo.sv
// Two-entry beat FIFO; the head entry is a register so downstream sees stable outputs.
module hist_beat_fifo
  import hist_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      din,
  input  logic       pop,
  output beat_t      head,
  output logic       head_vld,
  output logic [1:0] count
);
  beat_t tail;
  logic  tail_vld;

  assign count = {1'b0, head_vld} + {1'b0, tail_vld};

  // Overflow is prevented upstream by the read credit, so push at full is not handled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      head_vld <= 1'b0;
      tail     <= '0;
      tail_vld <= 1'b0;
    end else if (pop && head_vld) begin
      if (tail_vld) begin
        head     <= tail;
        tail_vld <= push;
        if (push) tail <= din;
      end else begin
        head_vld <= push;
        if (push) head <= din;
      end
    end else if (push) begin
      if (!head_vld) begin
        head     <= din;
        head_vld <= 1'b1;
      end else begin
        tail     <= din;
        tail_vld <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/histogram_stream_reader.sv
// Sweeps all histogram bins through the calculator read port and streams
// (bin, count, cdf) beats; reports the frame total with a done pulse.
module histogram_stream_reader
  import hist_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  histogram_stream_reader_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic [CDF_W-1:0]          total
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [BIN_W-1:0]  issue_idx, cap_bin;
  logic              inflight;
  logic [CDF_W-1:0]  acc;
  logic              start_acc, finish, rd_en, pop, head_vld;
  logic [1:0]        fifo_count, credit_used;
  beat_t             head, push_beat;

  assign pop = head_vld & bus.out_ready;
  // Credit counts the slot freed by this cycle's pop so a full-rate stream
  // keeps one read issued per cycle; occupancy never exceeds two.
  assign credit_used = fifo_count + {1'b0, inflight} - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    start_acc = 1'b0;
    finish    = 1'b0;
    case (state_q)
      IDLE: if (start && !done) begin
        start_acc = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        rd_en = (credit_used < 2'd2);
        if (rd_en && issue_idx == BIN_W'(NBINS-1)) state_d = DRAIN;
      end
      DRAIN: if (pop && head.last) begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      issue_idx <= '0;
      cap_bin   <= '0;
      inflight  <= 1'b0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      total     <= '0;
    end else begin
      state_q  <= state_d;
      done     <= finish;
      inflight <= rd_en;
      if (rd_en) begin
        issue_idx <= issue_idx + 1'b1;
        cap_bin   <= issue_idx;
      end
      if (start_acc) begin
        base_q    <= base_addr;
        issue_idx <= '0;
        acc       <= '0;
        busy      <= 1'b1;
        total     <= '0;
      end else begin
        if (inflight) acc <= push_beat.cdf;
        if (finish) begin
          busy  <= 1'b0;
          total <= acc;
        end
      end
    end
  end

  always_comb begin
    push_beat       = '0;
    push_beat.bin   = cap_bin;
    push_beat.count = bus.rd_data;
    push_beat.cdf   = acc + CDF_W'(bus.rd_data);
    push_beat.last  = (cap_bin == BIN_W'(NBINS-1));
  end

  hist_beat_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .din      (push_beat),
    .pop      (bus.out_ready),
    .head     (head),
    .head_vld (head_vld),
    .count    (fifo_count)
  );

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = base_q + ADDR_W'(issue_idx);
  assign bus.out_valid = head_vld;
  assign bus.out_bin   = head.bin;
  assign bus.out_count = head.count;
  assign bus.out_cdf   = head.cdf;
  assign bus.out_last  = head.last;
endmodule

// File: tb/tb_histogram_stream_reader.sv
// Directed bench: cycle-table for the nominal sweep plus hand sequences for corner cases.
module tb_histogram_stream_reader;
  import hist_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, busy, done;
  logic [ADDR_W-1:0] base_addr;
  logic [CDF_W-1:0]  total;
  logic              rand_ready = 1'b0;

  histogram_stream_reader_if bus();

  histogram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .bus(bus), .busy(busy), .done(done), .total(total)
  );

  always #5 clk = ~clk;

  logic [CNT_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream monitor: reference sweep model restarted on every start the DUT should accept.
  int               beats, dones, issued, occ, exp_bin;
  logic [ADDR_W-1:0] mbase, maddr;
  logic [CDF_W-1:0] mdl_acc, last_cdf;
  logic             prev_stall;
  logic [BIN_W-1:0] prev_bin;
  logic [CNT_W-1:0] prev_cnt;
  logic [CDF_W-1:0] prev_cdf;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      occ        = 0;
    end else begin
      if (start && !busy && !done) begin
        beats = 0; dones = 0; issued = 0; occ = 0; exp_bin = 0;
        mbase = base_addr; mdl_acc = '0; last_cdf = '0;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_bin",   32'(bus.out_bin),   32'(prev_bin));
        chk("stall_count", 32'(bus.out_count), 32'(prev_cnt));
        chk("stall_cdf",   32'(bus.out_cdf),   32'(prev_cdf));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_bin = bus.out_bin; prev_cnt = bus.out_count; prev_cdf = bus.out_cdf;
      if (bus.rd_en) begin
        maddr = mbase + ADDR_W'(issued);
        chk("rd_addr", 32'(bus.rd_addr), 32'(maddr));
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        maddr   = mbase + ADDR_W'(exp_bin);
        mdl_acc = mdl_acc + CDF_W'(mem[maddr]);
        chk("beat_bin",   32'(bus.out_bin),   32'(exp_bin));
        chk("beat_count", 32'(bus.out_count), 32'(mem[maddr]));
        chk("beat_cdf",   32'(bus.out_cdf),   32'(mdl_acc));
        chk("beat_last",  32'(bus.out_last),  32'(exp_bin == NBINS-1));
        if (bus.out_last) last_cdf = bus.out_cdf;
        exp_bin++;
        beats++;
      end
      occ = occ + int'(bus.rd_en) - int'(bus.out_valid && bus.out_ready);
      chk("occupancy_le2", 32'(occ <= 2), 32'd1);
      if (done) dones++;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] b);
    base_addr = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin tick(); n++; end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic load_basic;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    mem[0] = 16'd1; mem[1] = 16'd3; mem[2] = 16'd1; mem[3] = 16'd1; mem[4] = 16'd1;
  endtask

  typedef struct {
    int   cyc;
    logic rd_en, vld;
    int   bin, cdf;
    logic last, dn, bsy;
  } vec_t;
  vec_t vecs [0:12];

  initial begin
    int cur, sum;
    vecs[0]  = '{1,   1, 0, 0,   0, 0, 0, 1};
    vecs[1]  = '{2,   1, 0, 0,   0, 0, 0, 1};
    vecs[2]  = '{3,   1, 1, 0,   1, 0, 0, 1};
    vecs[3]  = '{4,   1, 1, 1,   4, 0, 0, 1};
    vecs[4]  = '{5,   1, 1, 2,   5, 0, 0, 1};
    vecs[5]  = '{6,   1, 1, 3,   6, 0, 0, 1};
    vecs[6]  = '{7,   1, 1, 4,   7, 0, 0, 1};
    vecs[7]  = '{8,   1, 1, 5,   7, 0, 0, 1};
    vecs[8]  = '{256, 1, 1, 253, 7, 0, 0, 1};
    vecs[9]  = '{257, 0, 1, 254, 7, 0, 0, 1};
    vecs[10] = '{258, 0, 1, 255, 7, 1, 0, 1};
    vecs[11] = '{259, 0, 0, 0,   0, 0, 1, 0};
    vecs[12] = '{260, 0, 0, 0,   0, 0, 0, 0};

    rst = 1'b1; start = 1'b0; base_addr = '0; bus.out_ready = 1'b1;
    load_basic();
    #1;
    chk("rst_rd_en", 32'(bus.rd_en), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_total", 32'(total), 0);
    chk("rst_beat",  32'({bus.out_bin, bus.out_last}) | 32'(bus.out_cdf) | 32'(bus.out_count), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Nominal sweep at full rate against the cycle table.
    base_addr = '0; start = 1'b1; cur = 0;
    foreach (vecs[k]) begin
      while (cur < vecs[k].cyc) begin
        tick(); cur++;
        start = 1'b0;
      end
      chk($sformatf("c%0d_rd_en", vecs[k].cyc), 32'(bus.rd_en), 32'(vecs[k].rd_en));
      chk($sformatf("c%0d_valid", vecs[k].cyc), 32'(bus.out_valid), 32'(vecs[k].vld));
      if (vecs[k].vld) begin
        chk($sformatf("c%0d_bin", vecs[k].cyc),  32'(bus.out_bin),  32'(vecs[k].bin));
        chk($sformatf("c%0d_cdf", vecs[k].cyc),  32'(bus.out_cdf),  32'(vecs[k].cdf));
        chk($sformatf("c%0d_last", vecs[k].cyc), 32'(bus.out_last), 32'(vecs[k].last));
      end
      chk($sformatf("c%0d_done", vecs[k].cyc), 32'(done), 32'(vecs[k].dn));
      chk($sformatf("c%0d_busy", vecs[k].cyc), 32'(busy), 32'(vecs[k].bsy));
    end
    chk("a_total", 32'(total), 32'd7);
    chk("a_beats", 32'(beats), 32'd256);

    // Random backpressure.
    rand_ready = 1'b1;
    pulse_start('0);
    wait_done("b_done_timeout", 3000);
    tick(); tick();
    rand_ready = 1'b0; bus.out_ready = 1'b1;
    chk("b_beats", 32'(beats), 32'd256);
    chk("b_dones", 32'(dones), 32'd1);
    chk("b_total", 32'(total), 32'd7);
    chk("b_last_cdf", 32'(last_cdf), 32'd7);

    // Non-zero bases, including one that wraps the address space.
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 16'((i * 37 + 5) & 16'hFFFF);
    for (int r = 0; r < 2; r++) begin
      logic [ADDR_W-1:0] b, a;
      b = (r == 0) ? ADDR_W'(256) : ADDR_W'(400);
      sum = 0;
      for (int i = 0; i < NBINS; i++) begin a = b + ADDR_W'(i); sum += int'(mem[a]); end
      pulse_start(b);
      wait_done($sformatf("base%0d_done_timeout", b), 1000);
      chk($sformatf("base%0d_total", b), 32'(total), 32'(sum));
      tick(); tick();
      chk($sformatf("base%0d_beats", b), 32'(beats), 32'd256);
    end

    // Full-scale bins reach the top of the cumulative range without wrapping.
    for (int i = 0; i < NBINS; i++) mem[i] = 16'hFFFF;
    pulse_start('0);
    wait_done("d_done_timeout", 1000);
    chk("d_total", 32'(total), 32'hFFFF00);
    chk("d_last_cdf", 32'(last_cdf), 32'hFFFF00);
    tick(); tick();

    // Starts during the sweep and in the done cycle are ignored.
    load_basic();
    pulse_start('0);
    cur = 1;
    while (cur < 100) begin
      if (cur == 10 || cur == 99) begin base_addr = 9'd77; start = 1'b1; end
      tick(); cur++;
      start = 1'b0;
    end
    wait_done("e_done_timeout", 1000);
    start = 1'b1; base_addr = 9'd77;
    tick();
    start = 1'b0;
    chk("e_busy_after_done_start", 32'(busy), 0);
    chk("e_rd_en_after_done_start", 32'(bus.rd_en), 0);
    tick(); tick();
    chk("e_dones", 32'(dones), 32'd1);
    chk("e_beats", 32'(beats), 32'd256);
    chk("e_total", 32'(total), 32'd7);

    // Reset mid-sweep, then a clean restart.
    pulse_start('0);
    for (int i = 1; i < 50; i++) tick();
    rst = 1'b1;
    #1;
    chk("f_rst_rd_en", 32'(bus.rd_en), 0);
    chk("f_rst_valid", 32'(bus.out_valid), 0);
    chk("f_rst_busy",  32'(busy), 0);
    chk("f_rst_total", 32'(total), 0);
    chk("f_rst_beat",  32'({bus.out_bin, bus.out_last}) | 32'(bus.out_cdf) | 32'(bus.out_count), 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("f_no_done", 32'(dones), 0);
    chk("f_idle_busy", 32'(busy), 0);
    pulse_start('0);
    tick(); tick();
    chk("f_first_valid", 32'(bus.out_valid), 32'd1);
    chk("f_first_bin",   32'(bus.out_bin), 0);
    chk("f_first_cdf",   32'(bus.out_cdf), 32'd1);
    wait_done("f_done_timeout", 1000);
    chk("f_total", 32'(total), 32'd7);
    tick(); tick();
    chk("f_beats", 32'(beats), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
